jump_control_stack: RTL and testbench

//   Next-generation PC-redirect controller for the pipelined MIPS-style core.

---
 rtl/jump_control_stack_if.sv | 36 +++
 rtl/jump_control_stack.sv | 148 ++++++++++++++
 tb/tb_jump_control_stack.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/jump_control_stack_if.sv
// PC-redirect bus between the execute stage and the jump/return-stack controller.
interface jump_control_stack_if #(
  parameter int INS_W       = 24,
  parameter int ADDR_W      = 8,
  parameter int FLAG_W      = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [INS_W-1:0]  ins;
  logic [ADDR_W-1:0] cur_addr;
  logic [FLAG_W-1:0] flag_ex;
  logic              irq;
  logic              int_en;
  logic              pc_mux_sel;
  logic [ADDR_W-1:0] jmp_loc;
  logic              int_ack;
  logic              flag_restore;
  logic [FLAG_W-1:0] flag_restore_val;
  logic              in_isr;
  logic [SP_W-1:0]   sp;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output ins, cur_addr, flag_ex, irq, int_en,
    input  pc_mux_sel, jmp_loc, int_ack, flag_restore,
    input  flag_restore_val, in_isr, sp, stack_ovf, stack_unf
  );

  modport slave (
    input  ins, cur_addr, flag_ex, irq, int_en,
    output pc_mux_sel, jmp_loc, int_ack, flag_restore,
    output flag_restore_val, in_isr, sp, stack_ovf, stack_unf
  );
endinterface

// File: rtl/jump_control_stack.sv
// Control-transfer decode, PC redirect and return stack
// with vectored interrupt entry.
module jump_control_stack #(
  parameter int              INS_W       = 24,
  parameter int              ADDR_W      = 8,
  parameter int              FLAG_W      = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] ISR_VECTOR = 8'hF0
) (
  input  logic clk,
  input  logic reset,
  jump_control_stack_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int E_W   = FLAG_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_VEC,
    ST_ISR
  } st_e;

  st_e              st_q;
  logic [E_W-1:0]   stk_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic             ovf_q;
  logic             unf_q;

  logic [4:0]        opc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] ret_addr;
  logic [E_W-1:0]    top;
  logic [IDX_W-1:0]  top_idx;
  logic              empty, full;
  logic              is_jc, is_jnc, is_jz, is_jnz;
  logic              is_jmp, is_call, is_ret, is_reti;
  logic              unused_ok;

  assign opc      = bus.ins[INS_W-1 -: 5];
  assign tgt      = bus.ins[ADDR_W-1:0];
  assign ret_addr = bus.cur_addr + 1'b1;
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign top_idx  = IDX_W'(sp_q - 1'b1);
  assign top      = stk_q[top_idx];
  assign unused_ok = ^bus.ins[INS_W-6:ADDR_W];

  assign is_jc   = (opc == 5'b11100);
  assign is_jnc  = (opc == 5'b11101);
  assign is_jz   = (opc == 5'b11110);
  assign is_jnz  = (opc == 5'b11111);
  assign is_jmp  = (opc == 5'b11000);
  assign is_call = (opc == 5'b11001);
  assign is_ret  = (opc == 5'b10000);
  assign is_reti = (opc == 5'b10001);

  logic              sel_d, ack_d, fr_d;
  logic [ADDR_W-1:0] loc_d;
  logic [FLAG_W-1:0] frv_d;
  logic              push, pop, unf_set, irq_take, reti;

  always_comb begin
    sel_d    = 1'b0;
    loc_d    = tgt;
    ack_d    = 1'b0;
    fr_d     = 1'b0;
    frv_d    = '0;
    push     = 1'b0;
    pop      = 1'b0;
    unf_set  = 1'b0;
    irq_take = 1'b0;
    reti     = 1'b0;
    if (st_q == ST_VEC) begin
      sel_d = 1'b1;
      loc_d = ISR_VECTOR;
      ack_d = 1'b1;
    end else begin
      unique case (1'b1)
        is_jc:   sel_d = bus.flag_ex[0];
        is_jnc:  sel_d = ~bus.flag_ex[0];
        is_jz:   sel_d = bus.flag_ex[1];
        is_jnz:  sel_d = ~bus.flag_ex[1];
        is_jmp:  sel_d = 1'b1;
        is_call: begin
          sel_d = 1'b1;
          push  = 1'b1;
        end
        is_ret, is_reti: begin
          reti = is_reti;
          if (empty) begin
            loc_d   = '0;
            unf_set = 1'b1;
          end else begin
            sel_d = 1'b1;
            loc_d = top[ADDR_W-1:0];
            pop   = 1'b1;
            fr_d  = is_reti;
            if (is_reti) frv_d = top[E_W-1 -: FLAG_W];
          end
        end
        default: begin
          // Entry is only taken on a non-transfer cycle
          if (bus.irq && bus.int_en && st_q != ST_ISR) begin
            push     = 1'b1;
            irq_take = 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.pc_mux_sel       = reset & sel_d;
  assign bus.jmp_loc          = reset ? loc_d : '0;
  assign bus.int_ack          = reset & ack_d;
  assign bus.flag_restore     = reset & fr_d;
  assign bus.flag_restore_val = reset ? frv_d : '0;
  assign bus.in_isr           = (st_q == ST_ISR);
  assign bus.sp               = sp_q;
  assign bus.stack_ovf        = ovf_q;
  assign bus.stack_unf        = unf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= ST_RUN;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push) begin
        if (full) ovf_q <= 1'b1;
        else      sp_q  <= sp_q + 1'b1;
      end
      if (pop)     sp_q  <= sp_q - 1'b1;
      if (unf_set) unf_q <= 1'b1;
      case (st_q)
        ST_RUN:  if (irq_take) st_q <= ST_VEC;
        ST_VEC:  st_q <= ST_ISR;
        ST_ISR:  if (reti) st_q <= ST_RUN;
        default: st_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) stk_q[IDX_W'(sp_q)] <= {bus.flag_ex, ret_addr};
  end
endmodule

// File: tb/tb_jump_control_stack.sv
// Randomised + directed bench for jump_control_stack,
// queue-based reference model and scoreboard.
module tb_jump_control_stack;
  localparam logic [4:0] OP_JC   = 5'b11100;
  localparam logic [4:0] OP_JNC  = 5'b11101;
  localparam logic [4:0] OP_JZ   = 5'b11110;
  localparam logic [4:0] OP_JNZ  = 5'b11111;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_CALL = 5'b11001;
  localparam logic [4:0] OP_RET  = 5'b10000;
  localparam logic [4:0] OP_RETI = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b00000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jump_control_stack_if bus ();

  jump_control_stack dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       sel;
    logic [7:0] loc;
    logic       chk_loc;
    logic       ack;
    logic       fr;
    logic [3:0] frv;
    logic       isr;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  logic [11:0] m_stk[$];
  bit m_isr, m_vp, m_ovf, m_unf;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void m_push(logic [3:0] f, logic [7:0] a);
    logic [7:0] r;
    r = a + 8'd1;
    if (m_stk.size() == 4) m_ovf = 1;
    else m_stk.push_back({f, r});
  endfunction

  task automatic model(input logic [23:0] i, input logic [7:0] a,
                       input logic [3:0] f, input logic rq,
                       input logic en, input logic rs, output exp_t e);
    logic [4:0] op;
    logic [11:0] ent;
    op = i[23:19];
    e = '0;
    if (!rs) begin
      m_stk.delete();
      m_isr = 0; m_vp = 0; m_ovf = 0; m_unf = 0;
      e.chk_loc = 1;
      return;
    end
    e.isr = m_isr;
    e.sp  = 3'(m_stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    if (m_vp) begin
      e.sel = 1; e.loc = 8'hF0; e.ack = 1; e.chk_loc = 1;
      m_vp = 0; m_isr = 1;
      return;
    end
    e.loc = i[7:0];
    if (op == OP_JC) e.sel = f[0];
    else if (op == OP_JNC) e.sel = !f[0];
    else if (op == OP_JZ) e.sel = f[1];
    else if (op == OP_JNZ) e.sel = !f[1];
    else if (op == OP_JMP) e.sel = 1;
    else if (op == OP_CALL) begin
      e.sel = 1;
      m_push(f, a);
    end else if (op == OP_RET || op == OP_RETI) begin
      if (m_stk.size() == 0) begin
        e.loc = 0; e.chk_loc = 1; m_unf = 1;
      end else begin
        ent = m_stk.pop_back();
        e.sel = 1; e.loc = ent[7:0];
        if (op == OP_RETI) begin e.fr = 1; e.frv = ent[11:8]; end
      end
      if (op == OP_RETI) m_isr = 0;
    end else begin
      e.chk_loc = 1;
      if (rq && en && !m_isr) begin
        m_push(f, a);
        m_vp = 1;
      end
    end
    if (e.sel) e.chk_loc = 1;
  endtask

  task automatic cyc(input logic [4:0] op, input logic [7:0] t,
                     input logic [7:0] a, input logic [3:0] f,
                     input logic rq, input logic en, input logic rs);
    exp_t e;
    logic [23:0] i;
    i = {op, 11'($urandom), t};
    @(posedge clk); #1;
    bus.ins = i; bus.cur_addr = a; bus.flag_ex = f;
    bus.irq = rq; bus.int_en = en; rst_n = rs;
    model(i, a, f, rq, en, rs, e);
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pc_mux_sel", 32'(bus.pc_mux_sel), 32'(e.sel));
      if (e.chk_loc) chk("jmp_loc", 32'(bus.jmp_loc), 32'(e.loc));
      chk("int_ack", 32'(bus.int_ack), 32'(e.ack));
      chk("flag_restore", 32'(bus.flag_restore), 32'(e.fr));
      if (e.fr) chk("flag_restore_val", 32'(bus.flag_restore_val), 32'(e.frv));
      chk("in_isr", 32'(bus.in_isr), 32'(e.isr));
      chk("sp", 32'(bus.sp), 32'(e.sp));
      chk("stack_ovf", 32'(bus.stack_ovf), 32'(e.ovf));
      chk("stack_unf", 32'(bus.stack_unf), 32'(e.unf));
    end
  end

  logic [4:0] ops [8] = '{OP_JC, OP_JNC, OP_JZ, OP_JNZ,
                          OP_JMP, OP_CALL, OP_RET, OP_RETI};

  initial begin
    bus.ins = '0; bus.cur_addr = '0; bus.flag_ex = '0;
    bus.irq = 0; bus.int_en = 0;
    cyc(OP_JMP, 8'h33, 8'h00, 4'h0, 1, 1, 0);
    cyc(OP_NOP, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    // conditional jumps
    cyc(OP_JC,  8'h40, 8'h01, 4'b0001, 0, 0, 1);
    cyc(OP_JNC, 8'h40, 8'h02, 4'b0001, 0, 0, 1);
    cyc(OP_JZ,  8'h44, 8'h03, 4'b0010, 0, 0, 1);
    cyc(OP_JNZ, 8'h44, 8'h04, 4'b0010, 0, 0, 1);
    cyc(OP_NOP, 8'h5A, 8'h05, 4'b0000, 0, 0, 1);
    // fill, overflow, drain, underflow
    for (int k = 1; k <= 5; k++)
      cyc(OP_CALL, 8'(8'h80 + k), 8'(k * 16), 4'(k), 0, 0, 1);
    for (int k = 0; k < 5; k++)
      cyc(OP_RET, 8'h00, 8'h60, 4'h0, 0, 0, 1);
    cyc(OP_CALL, 8'h10, 8'hFF, 4'h3, 0, 0, 1);
    cyc(OP_RET, 8'h00, 8'h11, 4'h0, 0, 0, 1);
    // interrupt entry and return
    cyc(OP_NOP, 8'h00, 8'h20, 4'hA, 1, 1, 1);
    cyc(OP_NOP, 8'h00, 8'h21, 4'h0, 0, 1, 1);
    cyc(OP_NOP, 8'h00, 8'hF0, 4'h0, 1, 1, 1);
    cyc(OP_RETI, 8'h00, 8'hF1, 4'h0, 0, 1, 1);
    // deferred entry behind a jump
    cyc(OP_JMP, 8'h50, 8'h30, 4'h5, 1, 1, 1);
    cyc(OP_NOP, 8'h00, 8'h50, 4'h6, 1, 1, 1);
    cyc(OP_NOP, 8'h00, 8'h51, 4'h0, 1, 1, 1);
    cyc(OP_NOP, 8'h00, 8'hF0, 4'h0, 1, 1, 1);
    cyc(OP_RETI, 8'h00, 8'hF1, 4'h0, 0, 1, 1);
    // reset during the vector cycle
    cyc(OP_NOP, 8'h00, 8'h70, 4'h1, 1, 1, 1);
    cyc(OP_NOP, 8'h00, 8'h71, 4'h0, 0, 1, 0);
    cyc(OP_NOP, 8'h00, 8'h71, 4'h0, 0, 1, 1);
    cyc(OP_NOP, 8'h00, 8'h72, 4'h0, 0, 1, 1);
    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] op;
      int r;
      r = $urandom_range(0, 11);
      op = (r < 8) ? ops[r] : 5'($urandom);
      cyc(op, 8'($urandom), 8'($urandom), 4'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 249) != 0);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
